seg_dynamic: RTL
================

# seg_dynamic

Dynamic-scan driver for the six-digit seven-segment display. It consumes the 20-bit binary value, decimal-point mask, sign flag and enable produced by the upstream data generator, and converts the value to BCD with a sequential double-dabble. It then time-multiplexes the six digits, producing registered digit-select and segment codes for the downstream 74HC595 shift-register controller.

## Interface
- CNT_MAX, 16'd49_999: scan slot length minus one, in sys_clk cycles (1 ms at 50 MHz).
- sys_clk  input  1  system clock; all logic on its rising edge.
- sys_rst_n  input  1  asynchronous, active-low reset.
- data  input  20  unsigned binary value to display.
- point  input  6  decimal-point mask; bit i lights the DP of digit i (digit 0 = rightmost).
- sign  input  1  1 = show a minus sign.
- seg_en  input  1  display enable.
- sel  output  6  one-hot digit select, active-high; bit i drives digit i.
- seg  output  8  segment code, active-low, common-anode; {dp,g,f,e,d,c,b,a}.

## Operation
- **Saturation:** if data > 999_999, the value converted is 999_999.
- **BCD converter states:** IDLE, SHIFT, DONE.
  - IDLE → SHIFT when data differs from the last captured value; data is captured on that edge.
  - SHIFT performs 20 add-3/shift iterations, one per cycle.
  - DONE writes the six BCD digits into the display register, then returns to IDLE.
  - data changes during SHIFT are ignored; the new value is picked up on the next IDLE check.
- **Most significant digit:** msd = index of the highest nonzero BCD digit (0 if the value is 0).
- **Leftmost lit digit:** lim = max(msd, index of the highest set bit of point).
- **Blanking:** digits above lim are blank. Digit 0 is never blanked.
- **Sign:** if sign = 1 and lim < 5, digit lim+1 shows '-' (8'hBF). If lim = 5, the sign is dropped.
- **Encoding:** 0–9 = C0,F9,A4,B0,99,92,82,F8,80,90 (hex, dp off). Blank = 8'hFF.
  - dp is applied after encoding: point[i] = 1 clears seg[7] on digit i, including a blank or '-' digit.
- **Scan:**
  - A counter runs 0..CNT_MAX and wraps.
  - On wrap, the digit index advances 0→1→…→5→0.
  - sel = 1 << index; seg = the code for that index.
- **seg_en = 0:** sel = 6'b000000, seg = 8'hFF. The scan counter and index are held at 0. The converter keeps running.
- **seg_en 0→1:** the first slot is digit 0, of full length.

## Timing
- **Reset values:** sel = 0, seg = 8'hFF, counter = 0, index = 0, BCD register = 0, converter in IDLE, captured value = 0.
  - data = 0 at reset therefore starts no conversion. The display shows "0" once enabled.
- **Conversion latency:** data change to BCD register update = 22 cycles (1 capture + 20 shift + 1 done).
- **Output registers:** sel and seg are registered and change together, one cycle after the index update.
  - The index updates on the edge where counter == CNT_MAX.
  - Every slot is exactly CNT_MAX+1 cycles.
- **Display updates:** a new BCD value is shown from the next slot boundary; no partial-slot glitches.
  - The segment code is recomputed from the display register at every edge; only the registered output is visible.
- **seg_en deassertion:** blanks the outputs on the next edge.
- **Asynchronous reset mid-conversion:** aborts the conversion and returns all state to reset values.

## Structure
- **Package seg_pkg:**
  - NUM_DIGITS = 6.
  - Digit-code constants SEG_0..SEG_9.
  - SEG_BLANK = 8'hFF, SEG_MINUS = 8'hBF.
  - Converter state enum {IDLE, SHIFT, DONE}.
- **Sub-module bin2bcd:** sequential double-dabble.
  - Ports: sys_clk, sys_rst_n, start, bin[19:0], busy, done, bcd[23:0].
  - Contains the FSM and the 5-bit iteration counter.
- **Top level:** saturation, change detection, msd/lim logic, scan counter, encoder, output registers.

## Test plan
All scenarios use CNT_MAX = 9 and seg_en = 1 unless stated.
- **Basic value:** data = 20'd123, point = 0, sign = 0 → per slot, digit 0 = 8'hB0, digit 1 = 8'hA4, digit 2 = 8'hF9, digits 3–5 = 8'hFF; sel cycles 01,02,04,08,10,20 every 10 cycles.
- **Sign and point:** data = 5, point = 6'b000100, sign = 1 → digit 0 = 92, digit 1 = C0, digit 2 = 40 (0 with dp), digit 3 = BF, digits 4–5 = FF.
- **Saturation and dropped sign:** data = 20'hFFFFF, sign = 1 → all six digits = 8'h90; no '-' shown.
- **Conversion latency:** change data 0 → 999_999 at cycle T → BCD register = 24'h999999 at T+22; the display shows it from the first slot boundary after that.
- **Enable and reset mid-scan:** seg_en = 0 mid-slot → next edge sel = 0, seg = FF. seg_en = 1 → sel = 01 for 10 cycles. sys_rst_n pulsed low during SHIFT → all outputs at reset values immediately.
- **Value of zero:** data = 0, point = 0, sign = 0 → digit 0 = C0, digits 1–5 = FF.

Source files
------------

// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared constants, types and helpers for the six-digit dynamic-scan display.
//   NUM_DIGITS      number of display digits
//   DATA_MAX        largest value that fits in six decimal digits
//   SEG_0..SEG_9    active-low common-anode digit codes {dp,g,f,e,d,c,b,a}
//   SEG_BLANK       all segments off
//   SEG_MINUS       only segment g lit
//   conv_state_t    binary-to-BCD converter states
//   seg_encode()    BCD digit to segment code (dp off)
// -----------------------------------------------------------------------------
package seg_pkg;

    localparam int          NUM_DIGITS = 6;
    localparam logic [19:0] DATA_MAX   = 20'd999_999;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_t;

    function automatic logic [7:0] seg_encode(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_dynamic_bin2bcd.sv
// -----------------------------------------------------------------------------
// bin2bcd
// Sequential double-dabble: one add-3/shift iteration per clock, 20 iterations.
//   sys_clk    system clock
//   sys_rst_n  asynchronous active-low reset
//   start      load bin and begin a conversion (honoured only in IDLE)
//   bin        binary value, must be <= 999_999
//   busy       high while shifting
//   done       high in the cycle the result is written to bcd
//   bcd        six packed BCD digits, digit 0 in bcd[3:0]; holds last result
// -----------------------------------------------------------------------------
module bin2bcd
    import seg_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [19:0] bin,
    output logic        busy,
    output logic        done,
    output logic [23:0] bcd
);

    localparam logic [4:0] LAST_ITER = 5'd19;

    conv_state_t state, state_nxt;
    logic [4:0]  iter;
    logic [43:0] work;      // {bcd digits, remaining binary bits}

    // Add 3 to every BCD nibble that is 5 or more, so the following
    // left shift carries correctly into the next decimal digit.
    function automatic logic [43:0] dabble(input logic [43:0] w);
        logic [43:0] r;
        r = w;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r[20+4*d +: 4] >= 4'd5)
                r[20+4*d +: 4] = r[20+4*d +: 4] + 4'd3;
        end
        return r;
    endfunction

    // NOTE: sequential state uses <= so every register samples pre-edge values;
    // blocking = here would make results depend on statement order.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // NOTE: the default assignment first keeps every path assigned, so no
    // latch is inferred for state_nxt.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (iter == LAST_ITER) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the working register and result are reset too, so an aborted
    // conversion never leaves stale digits behind after reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            work <= '0;
            iter <= '0;
            bcd  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work <= {24'd0, bin};
                        iter <= '0;
                    end
                end
                SHIFT: begin
                    work <= dabble(work) << 1;
                    iter <= iter + 5'd1;
                end
                DONE:    bcd <= work[43:20];
                default: ;
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: rtl/seg_dynamic.sv
// -----------------------------------------------------------------------------
// seg_dynamic
// Dynamic-scan driver for a six-digit seven-segment display. Saturates and
// converts the input value to BCD, applies leading-zero blanking, sign and
// decimal points, and scans one digit per slot of CNT_MAX+1 clocks.
//   sys_clk    system clock
//   sys_rst_n  asynchronous active-low reset
//   data       unsigned binary value to display
//   point      decimal-point mask, bit i = digit i (digit 0 rightmost)
//   sign       show a minus sign left of the leftmost lit digit
//   seg_en     display enable; when low outputs are dark and scan is held
//   sel        one-hot digit select, active-high (registered)
//   seg        segment code, active-low {dp,g,f,e,d,c,b,a} (registered)
// -----------------------------------------------------------------------------
module seg_dynamic
    import seg_pkg::*;
#(
    parameter logic [15:0] CNT_MAX = 16'd49_999
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [19:0] data,
    input  logic [5:0]  point,
    input  logic        sign,
    input  logic        seg_en,
    output logic [5:0]  sel,
    output logic [7:0]  seg
);

    logic [19:0] sat_data;
    logic [19:0] captured;
    logic        start;
    logic        busy;
    logic        done;
    logic [23:0] bcd;

    logic [3:0]  digit [NUM_DIGITS];
    logic [7:0]  code  [NUM_DIGITS];
    logic [2:0]  msd;
    logic [2:0]  pt_hi;
    logic [2:0]  lim;

    logic [15:0] cnt;
    logic [2:0]  idx;

    assign sat_data = (data > DATA_MAX) ? DATA_MAX : data;

    // Convert only when the converter is idle and the value has changed;
    // changes during a conversion are picked up on the next idle check.
    assign start = (sat_data != captured) && !busy && !done;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)  captured <= '0;
        else if (start)  captured <= sat_data;
    end

    bin2bcd u_bcd (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .bin       (sat_data),
        .busy      (busy),
        .done      (done),
        .bcd       (bcd)
    );

    // Leftmost lit digit is the higher of the most significant nonzero digit
    // and the leftmost decimal point; digit 0 is always lit.
    always_comb begin
        msd   = '0;
        pt_hi = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit[i] = bcd[4*i +: 4];
            if (digit[i] != 4'd0) msd   = 3'(i);
            if (point[i])         pt_hi = 3'(i);
        end
        lim = (msd > pt_hi) ? msd : pt_hi;

        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i <= int'(lim))
                code[i] = seg_encode(digit[i]);
            else if (sign && (i == int'(lim) + 1))
                code[i] = SEG_MINUS;
            else
                code[i] = SEG_BLANK;
            if (point[i]) code[i][7] = 1'b0;
        end
    end

    // Outputs load only at a slot start (cnt == 0), so a value, point or sign
    // change becomes visible at the next slot boundary, never mid-slot.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= '0;
            idx <= '0;
            sel <= '0;
            seg <= SEG_BLANK;
        end else if (!seg_en) begin
            cnt <= '0;
            idx <= '0;
            sel <= '0;
            seg <= SEG_BLANK;
        end else begin
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                idx <= (idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
            end else begin
                cnt <= cnt + 16'd1;
            end
            if (cnt == 16'd0) begin
                sel <= 6'd1 << idx;
                seg <= code[idx];
            end
        end
    end

endmodule
